// File: rtl/downsample_frame_ctrl.sv
// -----------------------------------------------------------------------------
// downsample_frame_ctrl
//   Frame-level controller for the 2D stream decimator. A frame configuration
//   (width, height, horizontal/vertical log2 step) is captured when a start is
//   accepted. The controller then walks the x/y raster one source transfer at
//   a time. It forwards one pixel out of every (2^xshift x 2^yshift) block and
//   consumes the rest without waiting on the sink. It also marks the last kept
//   pixel and reports busy/done plus a wrapping count of completed frames.
//
// Ports
//   CLK             clock, rising edge
//   RESET           asynchronous active-high reset
//   start           start-of-frame request (IDLE only)
//   abort           terminate current frame (RUN only)
//   cfg_width       pixels per line, captured on accepted start
//   cfg_height      lines per frame, captured on accepted start
//   cfg_xshift      log2 horizontal decimation step, captured on accepted start
//   cfg_yshift      log2 vertical decimation step, captured on accepted start
//   data_in_valid   source pixel valid
//   data_in_data    source pixel
//   data_in_ready   controller accepts source pixel
//   data_out_valid  kept pixel valid to sink
//   data_out_data   kept pixel (pass-through of data_in_data)
//   data_out_last   last kept pixel of the frame
//   data_out_ready  sink ready
//   busy            high while in RUN or DONE
//   done            one-cycle pulse on normal frame completion
//   frame_count     completed frames, wraps
// -----------------------------------------------------------------------------
module downsample_frame_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int DIM_WIDTH   = 5,
    parameter int SHIFT_WIDTH = 2,
    parameter int FCNT_WIDTH  = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DIM_WIDTH-1:0]   cfg_width,
    input  logic [DIM_WIDTH-1:0]   cfg_height,
    input  logic [SHIFT_WIDTH-1:0] cfg_xshift,
    input  logic [SHIFT_WIDTH-1:0] cfg_yshift,
    input  logic                   data_in_valid,
    input  logic [DATA_WIDTH-1:0]  data_in_data,
    output logic                   data_in_ready,
    output logic                   data_out_valid,
    output logic [DATA_WIDTH-1:0]  data_out_data,
    output logic                   data_out_last,
    input  logic                   data_out_ready,
    output logic                   busy,
    output logic                   done,
    output logic [FCNT_WIDTH-1:0]  frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DIM_WIDTH-1:0]  DIM_ZERO  = {DIM_WIDTH{1'b0}};
    localparam logic [DIM_WIDTH-1:0]  DIM_ONE   = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [FCNT_WIDTH-1:0] FCNT_ONE  = {{(FCNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [FCNT_WIDTH-1:0] FCNT_ZERO = {FCNT_WIDTH{1'b0}};

    // Mask of the low position bits that must be zero for a kept pixel.
    function automatic logic [DIM_WIDTH-1:0] step_mask(input logic [SHIFT_WIDTH-1:0] shift);
        step_mask = ~({DIM_WIDTH{1'b1}} << shift);
    endfunction

    state_t                 state_r;
    logic [DIM_WIDTH-1:0]   x_r;
    logic [DIM_WIDTH-1:0]   y_r;
    logic [DIM_WIDTH-1:0]   xend_r;      // width-1 of the latched frame
    logic [DIM_WIDTH-1:0]   yend_r;      // height-1 of the latched frame
    logic [DIM_WIDTH-1:0]   xmask_r;
    logic [DIM_WIDTH-1:0]   ymask_r;
    logic [DIM_WIDTH-1:0]   last_kx_r;   // x of the last kept column
    logic [DIM_WIDTH-1:0]   last_ky_r;   // y of the last kept row
    logic                   busy_r;
    logic                   done_r;
    logic [FCNT_WIDTH-1:0]  frame_count_r;

    logic run_s;
    logic keep_s;
    logic in_ready_s;
    logic out_valid_s;
    logic xfer_s;
    logic at_end_s;

    // Handshake decode; abort blocks any transfer in the cycle it is seen.
    always_comb begin
        run_s       = (state_r == ST_RUN);
        keep_s      = run_s
                    & ((x_r & xmask_r) == DIM_ZERO)
                    & ((y_r & ymask_r) == DIM_ZERO);
        in_ready_s  = run_s & ~abort & (data_out_ready | ~keep_s);
        out_valid_s = run_s & ~abort & keep_s & data_in_valid;
        xfer_s      = data_in_valid & in_ready_s;
        at_end_s    = (x_r == xend_r) & (y_r == yend_r);
    end

    // Output drive; handshake outputs are combinational so no latency is added.
    always_comb begin
        data_in_ready  = in_ready_s;
        data_out_valid = out_valid_s;
        data_out_data  = data_in_data;
        data_out_last  = out_valid_s & (x_r == last_kx_r) & (y_r == last_ky_r);
        busy           = busy_r;
        done           = done_r;
        frame_count    = frame_count_r;
    end

    // Frame FSM, raster position, captured configuration and status registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r       <= ST_IDLE;
            x_r           <= DIM_ZERO;
            y_r           <= DIM_ZERO;
            xend_r        <= DIM_ZERO;
            yend_r        <= DIM_ZERO;
            xmask_r       <= DIM_ZERO;
            ymask_r       <= DIM_ZERO;
            last_kx_r     <= DIM_ZERO;
            last_ky_r     <= DIM_ZERO;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            frame_count_r <= FCNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        x_r       <= DIM_ZERO;
                        y_r       <= DIM_ZERO;
                        xend_r    <= cfg_width - DIM_ONE;
                        yend_r    <= cfg_height - DIM_ONE;
                        xmask_r   <= step_mask(cfg_xshift);
                        ymask_r   <= step_mask(cfg_yshift);
                        last_kx_r <= (cfg_width - DIM_ONE) & ~step_mask(cfg_xshift);
                        last_ky_r <= (cfg_height - DIM_ONE) & ~step_mask(cfg_yshift);
                        busy_r    <= 1'b1;
                        // An empty raster completes at once without transfers.
                        if ((cfg_width == DIM_ZERO) || (cfg_height == DIM_ZERO)) begin
                            state_r       <= ST_DONE;
                            done_r        <= 1'b1;
                            frame_count_r <= frame_count_r + FCNT_ONE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        x_r     <= DIM_ZERO;
                        y_r     <= DIM_ZERO;
                        busy_r  <= 1'b0;
                    end else if (xfer_s) begin
                        if (at_end_s) begin
                            state_r       <= ST_DONE;
                            x_r           <= DIM_ZERO;
                            y_r           <= DIM_ZERO;
                            done_r        <= 1'b1;
                            frame_count_r <= frame_count_r + FCNT_ONE;
                        end else if (x_r == xend_r) begin
                            x_r <= DIM_ZERO;
                            y_r <= y_r + DIM_ONE;
                        end else begin
                            x_r <= x_r + DIM_ONE;
                        end
                    end else begin
                        x_r <= x_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    x_r     <= DIM_ZERO;
                    y_r     <= DIM_ZERO;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_downsample_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_downsample_frame_ctrl
//   Directed frame sequence with randomized source/sink handshakes. The
//   expected kept-pixel stream of each frame is built up front from the
//   raster dimensions and decimation steps, then consumed as pixels leave.
// -----------------------------------------------------------------------------
module tb_downsample_frame_ctrl;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic        abort;
    logic [4:0]  cfg_width;
    logic [4:0]  cfg_height;
    logic [1:0]  cfg_xshift;
    logic [1:0]  cfg_yshift;
    logic        data_in_valid;
    logic [15:0] data_in_data;
    logic        data_in_ready;
    logic        data_out_valid;
    logic [15:0] data_out_data;
    logic        data_out_last;
    logic        data_out_ready;
    logic        busy;
    logic        done;
    logic [7:0]  frame_count;

    int          total;
    int          bad;
    logic [7:0]  fc;

    downsample_frame_ctrl dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .start          (start),
        .abort          (abort),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .cfg_xshift     (cfg_xshift),
        .cfg_yshift     (cfg_yshift),
        .data_in_valid  (data_in_valid),
        .data_in_data   (data_in_data),
        .data_in_ready  (data_in_ready),
        .data_out_valid (data_out_valid),
        .data_out_data  (data_out_data),
        .data_out_last  (data_out_last),
        .data_out_ready (data_out_ready),
        .busy           (busy),
        .done           (done),
        .frame_count    (frame_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: start, drive pixels with random handshakes, check every cycle.
    // abort_at >= 0 raises abort on the cycle the source offers that pixel index.
    task automatic run_frame(input int w, input int h, input int xs, input int ys,
                             input int vpct, input int rpct, input int abort_at);
        int          n;
        int          p;
        int          cyc;
        int          x;
        int          y;
        logic [15:0] pix[$];
        logic [15:0] expq[$];
        logic [15:0] e;
        bit          kept;
        bit          exp_rdy;
        bit          aborted;
        n = w * h;
        for (int i = 0; i < n; i++) begin
            pix.push_back(16'($urandom));
            if (((i % w) % (1 << xs)) == 0 && ((i / w) % (1 << ys)) == 0)
                expq.push_back(pix[i]);
        end
        @(posedge CLK); #1;
        cfg_width  = 5'(w);
        cfg_height = 5'(h);
        cfg_xshift = 2'(xs);
        cfg_yshift = 2'(ys);
        start      = 1'b1;
        @(posedge CLK); #1;
        start   = 1'b0;
        p       = 0;
        cyc     = 0;
        aborted = 1'b0;
        while (p < n && !aborted && cyc < 2000) begin
            cyc++;
            x    = p % w;
            y    = p / w;
            kept = ((x % (1 << xs)) == 0) && ((y % (1 << ys)) == 0);
            data_in_valid  = ($urandom_range(99) < vpct);
            data_in_data   = pix[p];
            data_out_ready = ($urandom_range(99) < rpct);
            abort          = (p == abort_at);
            // Start and configuration noise while running must be ignored.
            start      = 1'($urandom);
            cfg_width  = 5'($urandom);
            cfg_height = 5'($urandom);
            cfg_xshift = 2'($urandom);
            cfg_yshift = 2'($urandom);
            @(negedge CLK);
            if (abort) begin
                chk("abort_in_ready", data_in_ready, 0);
                chk("abort_out_valid", data_out_valid, 0);
                chk("abort_busy", busy, 1);
                aborted = 1'b1;
            end else begin
                chk("run_busy", busy, 1);
                chk("run_done", done, 0);
                exp_rdy = kept ? data_out_ready : 1'b1;
                chk("in_ready", data_in_ready, exp_rdy);
                chk("out_valid", data_out_valid, kept && data_in_valid);
                if (kept && data_in_valid) begin
                    e = (expq.size() > 0) ? expq[0] : 16'hxxxx;
                    chk("out_data", data_out_data, e);
                    chk("out_last", data_out_last, expq.size() == 1);
                end else begin
                    chk("idle_last", data_out_last, 0);
                end
                if (data_in_valid && exp_rdy) begin
                    if (kept) void'(expq.pop_front());
                    p++;
                end
            end
            @(posedge CLK); #1;
        end
        start         = 1'b0;
        abort         = 1'b0;
        data_in_valid = 1'b0;
        if (aborted) begin
            @(negedge CLK);
            chk("post_abort_busy", busy, 0);
            chk("post_abort_done", done, 0);
            chk("post_abort_in_ready", data_in_ready, 0);
            chk("post_abort_fcount", frame_count, fc);
        end else begin
            if (p < n) chk("frame_timeout", p, n);
            @(negedge CLK);
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 1);
            chk("done_in_ready", data_in_ready, 0);
            chk("done_out_valid", data_out_valid, 0);
            chk("kept_left", expq.size(), 0);
            fc = fc + 8'd1;
            @(posedge CLK); #1;
            @(negedge CLK);
            chk("after_done", done, 0);
            chk("after_busy", busy, 0);
            chk("fcount", frame_count, fc);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        fc             = 8'd0;
        RESET          = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        cfg_width      = 5'd0;
        cfg_height     = 5'd0;
        cfg_xshift     = 2'd0;
        cfg_yshift     = 2'd0;
        data_in_valid  = 1'b1;
        data_in_data   = 16'h0;
        data_out_ready = 1'b1;

        // Reset state.
        @(negedge CLK);
        chk("rst_in_ready", data_in_ready, 0);
        chk("rst_out_valid", data_out_valid, 0);
        chk("rst_last", data_out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fcount", frame_count, 0);
        @(posedge CLK); #1;
        RESET         = 1'b0;
        data_in_valid = 1'b0;

        // 4x4 with 2x2 decimation, free-flowing; then 5x3.
        run_frame(4, 4, 1, 1, 100, 100, -1);
        run_frame(5, 3, 1, 1, 100, 100, -1);
        // Sink stalls on kept pixels, source gaps.
        run_frame(4, 4, 1, 1, 100, 40, -1);
        run_frame(5, 3, 1, 1, 70, 30, -1);
        // Abort after 5 transfers, then a full frame.
        run_frame(4, 4, 1, 1, 100, 100, 5);
        run_frame(4, 4, 1, 1, 100, 100, -1);
        // Empty rasters.
        run_frame(0, 4, 0, 0, 100, 100, -1);
        run_frame(3, 0, 0, 0, 100, 100, -1);
        // Full-size edge and random shapes.
        run_frame(31, 2, 3, 0, 90, 80, -1);
        for (int k = 0; k < 6; k++)
            run_frame($urandom_range(1, 9), $urandom_range(1, 9),
                      $urandom_range(0, 3), $urandom_range(0, 3), 70, 60, -1);

        // Reset mid-frame at (2,1).
        @(posedge CLK); #1;
        cfg_width  = 5'd4;
        cfg_height = 5'd4;
        cfg_xshift = 2'd0;
        cfg_yshift = 2'd0;
        start      = 1'b1;
        @(posedge CLK); #1;
        start          = 1'b0;
        data_in_valid  = 1'b1;
        data_out_ready = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        chk("pre_reset_in_ready", data_in_ready, 1);
        chk("pre_reset_busy", busy, 1);
        RESET = 1'b1;
        #1;
        chk("async_rst_in_ready", data_in_ready, 0);
        chk("async_rst_out_valid", data_out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_fcount", frame_count, 0);
        fc = 8'd0;
        @(posedge CLK); #1;
        RESET         = 1'b0;
        data_in_valid = 1'b0;
        @(negedge CLK);
        chk("post_rst_busy", busy, 0);
        run_frame(4, 4, 1, 1, 100, 100, -1);

        // Frame counter wrap: 255 more frames returns it to zero.
        for (int k = 0; k < 255; k++)
            run_frame(0, 0, 0, 0, 100, 100, -1);
        chk("fcount_wrap", frame_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
